runway_lights_decoder: RTL and testbench

RUNWAY_LIGHTS_DECODER -- requirements
Module: runway_lights_decoder

---
 rtl/runway_lights_decoder.sv | 177 +++++++++++++++++
 tb/tb_runway_lights_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/runway_lights_decoder.sv
`default_nettype none
// ============================================================================
// Module      : runway_lights_decoder
// Description : Infers a wind code from successive runway lamp patterns,
//               confirming it after CONFIRM agreeing observations.
// Revision    : 1.0 - initial release
// ============================================================================
module runway_lights_decoder #(
  parameter int CONFIRM = 3,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       lights,
  input  logic             sample,
  output logic [1:0]       wind,
  output logic             wind_valid,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [2:0]       c_pat_c   = 3'b010;
  localparam logic [2:0]       c_pat_o   = 3'b101;
  localparam logic [2:0]       c_pat_l   = 3'b100;
  localparam logic [2:0]       c_pat_r   = 3'b001;
  localparam logic [3:0]       c_confirm = 4'(CONFIRM);
  localparam logic [ERR_W-1:0] c_err_max = '1;

  state_t           r_state, w_state_n;
  logic [2:0]       r_prev, w_prev_n;
  logic [1:0]       r_cand, w_cand_n;
  logic [3:0]       r_cnt, w_cnt_n;
  logic [1:0]       r_wind, w_wind_n;
  logic             r_wind_valid, w_wind_valid_n;
  logic             r_err, w_err_n;
  logic [ERR_W-1:0] r_err_count, w_err_count_n;

  logic       w_legal;
  logic       w_info;
  logic       w_bad_tr;
  logic [1:0] w_d;
  logic [4:0] w_cnt_inc;
  logic [3:0] w_cnt_sat;

  // Classify the incoming pattern relative to the previously sampled one.
  always_comb begin
    w_legal  = (lights == c_pat_c) || (lights == c_pat_o) ||
               (lights == c_pat_l) || (lights == c_pat_r);
    w_info   = 1'b0;
    w_bad_tr = 1'b0;
    w_d      = 2'b00;
    case (r_prev)
      c_pat_c: begin
        w_info = 1'b1;
        case (lights)
          c_pat_c: w_d = 2'b11;
          c_pat_o: w_d = 2'b00;
          c_pat_l: w_d = 2'b01;
          c_pat_r: w_d = 2'b10;
          default: w_info = 1'b0;
        endcase
      end
      c_pat_o: w_bad_tr = (lights != c_pat_c);
      c_pat_l: begin
        case (lights)
          c_pat_l: begin w_info = 1'b1; w_d = 2'b11; end
          c_pat_r: begin w_info = 1'b1; w_d = 2'b01; end
          c_pat_o: w_bad_tr = 1'b1;
          default: ;
        endcase
      end
      c_pat_r: begin
        case (lights)
          c_pat_r: begin w_info = 1'b1; w_d = 2'b11; end
          c_pat_l: begin w_info = 1'b1; w_d = 2'b10; end
          c_pat_o: w_bad_tr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
  assign w_cnt_sat = (w_cnt_inc > {1'b0, c_confirm}) ? c_confirm : w_cnt_inc[3:0];

  always_comb begin
    w_state_n      = r_state;
    w_prev_n       = r_prev;
    w_cand_n       = r_cand;
    w_cnt_n        = r_cnt;
    w_wind_n       = r_wind;
    w_wind_valid_n = r_wind_valid;
    w_err_n        = 1'b0;
    if (sample) begin
      if (!w_legal) begin
        w_err_n        = 1'b1;
        w_state_n      = ST_IDLE;
        w_cnt_n        = 4'd0;
        w_wind_valid_n = 1'b0;
      end else if (r_state == ST_IDLE) begin
        w_prev_n  = lights;
        w_cnt_n   = 4'd0;
        w_state_n = ST_ACQUIRE;
      end else if (w_bad_tr) begin
        w_err_n        = 1'b1;
        w_prev_n       = lights;
        w_cnt_n        = 4'd0;
        w_wind_valid_n = 1'b0;
        w_state_n      = ST_ACQUIRE;
      end else if (w_info) begin
        w_prev_n = lights;
        if ((r_cnt != 4'd0) && (w_d == r_cand)) begin
          w_cnt_n = w_cnt_sat;
          if (w_cnt_sat == c_confirm) begin
            w_wind_n       = r_cand;
            w_wind_valid_n = 1'b1;
            w_state_n      = ST_LOCKED;
          end
        end else begin
          // A fresh candidate; with single-observation confirm it locks at once.
          w_cand_n = w_d;
          w_cnt_n  = 4'd1;
          if (CONFIRM == 1) begin
            w_wind_n       = w_d;
            w_wind_valid_n = 1'b1;
            w_state_n      = ST_LOCKED;
          end else begin
            w_wind_valid_n = 1'b0;
            w_state_n      = ST_ACQUIRE;
          end
        end
      end else begin
        w_prev_n = lights;
      end
    end
    w_err_count_n = r_err_count;
    if (w_err_n && (r_err_count != c_err_max)) begin
      w_err_count_n = r_err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prev       <= c_pat_c;
      r_cand       <= 2'b00;
      r_cnt        <= 4'd0;
      r_wind       <= 2'b00;
      r_wind_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_n;
      r_prev       <= w_prev_n;
      r_cand       <= w_cand_n;
      r_cnt        <= w_cnt_n;
      r_wind       <= w_wind_n;
      r_wind_valid <= w_wind_valid_n;
      r_err        <= w_err_n;
      r_err_count  <= w_err_count_n;
    end
  end

  assign wind       = r_wind;
  assign wind_valid = r_wind_valid;
  assign err        = r_err;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_runway_lights_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_runway_lights_decoder
// Description : Directed and randomized checks of two decoder configurations
//               against a pattern-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_runway_lights_decoder;

  localparam logic [2:0] c_c = 3'b010;
  localparam logic [2:0] c_o = 3'b101;
  localparam logic [2:0] c_l = 3'b100;
  localparam logic [2:0] c_r = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] lights = 3'b000;
  logic       sample = 1'b0;

  logic [1:0] wind_a, wind_b;
  logic       wv_a, wv_b, err_a, err_b;
  logic [7:0] ec_a;
  logic [1:0] ec_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  runway_lights_decoder #(.CONFIRM(3), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .lights(lights), .sample(sample),
    .wind(wind_a), .wind_valid(wv_a), .err(err_a), .err_count(ec_a));

  runway_lights_decoder #(.CONFIRM(1), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .lights(lights), .sample(sample),
    .wind(wind_b), .wind_valid(wv_b), .err(err_b), .err_count(ec_b));

  typedef struct packed {
    logic       have;
    logic [2:0] prev;
    logic [1:0] cand;
    logic [3:0] run;
    logic [1:0] wind;
    logic       valid;
    logic       err;
    logic [7:0] ec;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mreset();
    mstate_t n;
    n = '0;
    n.prev = c_c;
    return n;
  endfunction

  // Pattern index: C=0 O=1 L=2 R=3, -1 for illegal.
  function automatic int pidx(logic [2:0] p);
    if (p == c_c) return 0;
    if (p == c_o) return 1;
    if (p == c_l) return 2;
    if (p == c_r) return 3;
    return -1;
  endfunction

  // kind: 0 no information, 1 informative, 2 illegal transition
  function automatic void infer(logic [2:0] p, logic [2:0] l, output int kind, output logic [1:0] d);
    int ktab[4][4] = '{'{1, 1, 1, 1}, '{0, 2, 2, 2}, '{0, 2, 1, 1}, '{0, 2, 1, 1}};
    logic [1:0] dtab[4][4] = '{'{2'b11, 2'b00, 2'b01, 2'b10},
                               '{2'b00, 2'b00, 2'b00, 2'b00},
                               '{2'b00, 2'b00, 2'b11, 2'b01},
                               '{2'b00, 2'b00, 2'b10, 2'b11}};
    kind = ktab[pidx(p)][pidx(l)];
    d    = dtab[pidx(p)][pidx(l)];
  endfunction

  function automatic mstate_t mstep(mstate_t s, logic [2:0] l, logic smp, int confirm, int ecmax);
    mstate_t n;
    int kind, r;
    logic [1:0] d;
    n = s;
    n.err = 1'b0;
    if (!smp) return n;
    if (pidx(l) < 0) begin
      n.err = 1'b1; n.have = 1'b0; n.run = 0; n.valid = 1'b0;
    end else if (!s.have) begin
      n.have = 1'b1; n.prev = l; n.run = 0;
    end else begin
      infer(s.prev, l, kind, d);
      n.prev = l;
      if (kind == 2) begin
        n.err = 1'b1; n.run = 0; n.valid = 1'b0;
      end else if (kind == 1) begin
        if (s.run != 0 && d == s.cand) begin
          r = int'(s.run) + 1;
          if (r > confirm) r = confirm;
          n.run = 4'(r);
          if (r == confirm) begin n.wind = s.cand; n.valid = 1'b1; end
        end else begin
          n.cand = d; n.run = 1;
          if (confirm == 1) begin n.wind = d; n.valid = 1'b1; end
          else n.valid = 1'b0;
        end
      end
    end
    if (n.err && int'(s.ec) < ecmax) n.ec = s.ec + 8'd1;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.wind", {6'd0, wind_a}, {6'd0, ma.wind});
    chk("a.wind_valid", {7'd0, wv_a}, {7'd0, ma.valid});
    chk("a.err", {7'd0, err_a}, {7'd0, ma.err});
    chk("a.err_count", ec_a, ma.ec);
    chk("b.wind", {6'd0, wind_b}, {6'd0, mb.wind});
    chk("b.wind_valid", {7'd0, wv_b}, {7'd0, mb.valid});
    chk("b.err", {7'd0, err_b}, {7'd0, mb.err});
    chk("b.err_count", {6'd0, ec_b}, mb.ec);
  endtask

  task automatic cycle(input logic [2:0] l, input logic s);
    @(negedge clk);
    lights = l;
    sample = s;
    @(posedge clk);
    #1;
    ma = mstep(ma, l, s, 3, 255);
    mb = mstep(mb, l, s, 1, 3);
    check_all();
  endtask

  // Reset is raised between clock edges so the check below sees its async effect.
  task automatic do_reset();
    @(negedge clk);
    sample = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    ma = mreset();
    mb = mreset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] pats[4];
    logic [7:0] ec_exp[5];
    logic [2:0] last;
    pats   = '{c_c, c_o, c_l, c_r};
    ec_exp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    ma = mreset();
    mb = mreset();

    do_reset();
    for (int i = 0; i < 10; i++) cycle(3'($urandom), 1'b0);

    cycle(c_c, 1); cycle(c_o, 1); cycle(c_c, 1); cycle(c_o, 1); cycle(c_c, 1);
    chk("calm.pre_valid", {7'd0, wv_a}, 8'd0);
    cycle(c_o, 1);
    chk("calm.valid", {7'd0, wv_a}, 8'd1);
    chk("calm.wind", {6'd0, wind_a}, 8'd0);

    cycle(3'b111, 1);
    chk("ill.err", {7'd0, err_a}, 8'd1);
    chk("ill.count", ec_a, 8'd1);
    chk("ill.valid", {7'd0, wv_a}, 8'd0);
    cycle(c_c, 1);
    chk("ill.err_clear", {7'd0, err_a}, 8'd0);
    cycle(c_o, 1);
    chk("ill.reacquire", {7'd0, wv_a}, 8'd0);

    do_reset();
    cycle(c_c, 1); cycle(c_l, 1); cycle(c_r, 1); cycle(c_c, 1); cycle(c_l, 1);
    chk("rtl.valid", {7'd0, wv_a}, 8'd1);
    chk("rtl.wind", {6'd0, wind_a}, 8'd1);
    cycle(c_r, 1);
    cycle(c_l, 1);
    chk("rtl.drop", {7'd0, wv_a}, 8'd0);
    chk("rtl.hold", {6'd0, wind_a}, 8'd1);

    do_reset();
    cycle(c_o, 1); cycle(c_l, 1);
    chk("tr.err", {7'd0, err_a}, 8'd1);
    cycle(c_l, 1); cycle(c_l, 1); cycle(c_l, 1);
    chk("hold.wind", {6'd0, wind_a}, 8'd3);
    chk("hold.valid", {7'd0, wv_a}, 8'd1);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cycle(3'b111, 1);
      chk("sat.count", {6'd0, ec_b}, ec_exp[i]);
    end
    cycle(c_c, 1); cycle(c_o, 1);
    do_reset();

    last = c_c;
    for (int i = 0; i < 600; i++) begin
      logic [2:0] l;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) l = 3'($urandom);
        else if ($urandom_range(0, 1) == 0) l = last;
        else l = pats[$urandom_range(0, 3)];
        last = l;
        cycle(l, 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
